// File: rtl/coso_bit_extractor.sv
// coso_bit_extractor: measures beat periods, packs their LSBs into words (optional health monitor under COSO_HEALTH_EN)
module coso_bit_extractor #(
  parameter int CNT_W           = 16,
  parameter int BITS_PER_SAMPLE = 1,
  parameter int DATA_W          = 32,
  parameter int MIN_PERIOD      = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              beat,
  output logic [CNT_W-1:0]  countOut,
  output logic [DATA_W-1:0] dataOut,
  output logic              dataValid,
  input  logic              dataReady,
  output logic              overflow,
  output logic              alarm
);
  localparam int NB_W = $clog2(DATA_W + 1);
  logic              beat_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, count_q, count_d, period;
  logic              ref_q, ref_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic [DATA_W-1:0] sr_q, sr_d, data_q, data_d;
  logic              valid_q, valid_d, ovf_q, ovf_d;
  logic              rise, sat, sample, full, xfer;
  always_comb begin
    rise    = beat & ~beat_q;
    sat     = &cnt_q;
    period  = cnt_q + 1'b1;
    sample  = en & rise & ref_q & ~sat;
    full    = nb_q == NB_W'(DATA_W);
    xfer    = en & full & (~valid_q | dataReady);
    cnt_d   = !en ? cnt_q : rise ? '0 : sat ? cnt_q : cnt_q + 1'b1;
    ref_d   = en & (ref_q | rise);
    count_d = sample ? period : count_q;
    sr_d    = (sample & (~full | xfer)) ? {sr_q[DATA_W-BITS_PER_SAMPLE-1:0], period[BITS_PER_SAMPLE-1:0]} : sr_q;
    nb_d    = xfer ? (sample ? NB_W'(BITS_PER_SAMPLE) : '0)
            : (sample & ~full) ? nb_q + NB_W'(BITS_PER_SAMPLE) : nb_q;
    data_d  = xfer ? sr_q : data_q;
    valid_d = xfer | (valid_q & ~dataReady);
    ovf_d   = ovf_q | (sample & full & ~xfer);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      beat_q  <= 1'b0;
      cnt_q   <= '0;
      count_q <= '0;
      ref_q   <= 1'b0;
      nb_q    <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      beat_q  <= beat;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      ref_q   <= ref_d;
      nb_q    <= nb_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
`ifdef COSO_HEALTH_EN
  logic alarm_q, alarm_d;
  always_comb alarm_d = alarm_q | (sample & (period < CNT_W'(MIN_PERIOD))) | (en & ref_q & sat);
  always_ff @(posedge clk) begin
    if (clr) alarm_q <= 1'b0;
    else alarm_q <= alarm_d;
  end
  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif
  assign countOut  = count_q;
  assign dataOut   = data_q;
  assign dataValid = valid_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_coso_bit_extractor.sv
// tb_coso_bit_extractor: directed scoreboard bench for coso_bit_extractor (CNT_W=4, DATA_W=8)
module tb_coso_bit_extractor;
  logic       clk = 1'b0;
  logic       clr, en, beat, dataReady;
  logic [3:0] countOut;
  logic [7:0] dataOut;
  logic       dataValid, overflow, alarm;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] q[$];
`ifdef COSO_HEALTH_EN
  localparam logic ALARM_EXP = 1'b1;
`else
  localparam logic ALARM_EXP = 1'b0;
`endif

  coso_bit_extractor #(.CNT_W(4), .BITS_PER_SAMPLE(1), .DATA_W(8), .MIN_PERIOD(4)) dut (
    .clk(clk), .clr(clr), .en(en), .beat(beat), .countOut(countOut), .dataOut(dataOut),
    .dataValid(dataValid), .dataReady(dataReady), .overflow(overflow), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // beat rises p cycles after its previous rise, so the measured period is p
  task automatic gap(input int p);
    repeat (p - 1) begin
      beat = 1'b0;
      tick();
    end
    beat = 1'b1;
    tick();
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) gap(w[i] ? 7 : 6);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
  endtask

  task automatic reset();
    clr = 1'b1;
    beat = 1'b0;
    tick();
    tick();
    clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!clr && dataValid && dataReady) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL word_unexpected: got %0h expected none", dataOut);
      end else chk("word", dataOut, q.pop_front());
    end
  end

  initial begin
    en = 1'b0;
    dataReady = 1'b0;
    reset();
    chk("rst_count", countOut, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_valid", dataValid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_alarm", alarm, 0);
    // period sweep 5..13, first edge is the reference
    en = 1'b1;
    dataReady = 1'b1;
    q.push_back(8'h55);
    for (int p = 5; p <= 13; p++) gap(p);
    chk("sweep_count", countOut, 13);
    beat = 1'b0;
    tick();
    chk("sweep_valid_on", dataValid, 1);
    tick();
    chk("sweep_valid_off", dataValid, 0);
    drain();
    // backpressure
    dataReady = 1'b0;
    q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    chk("bp_ovf_before", overflow, 0);
    gap(6);
    chk("bp_hold", dataOut, 8'hA5);
    chk("bp_ovf_after", overflow, 1);
    dataReady = 1'b1;
    beat = 1'b0;
    drain();
    chk("bp_ovf_sticky", overflow, 1);
    // sample coincides with transfer and handshake
    reset();
    dataReady = 1'b0;
    gap(6);
    q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    repeat (5) begin
      beat = 1'b0;
      tick();
    end
    beat = 1'b1;
    dataReady = 1'b1;
    tick();
    chk("sim_ovf", overflow, 0);
    q.push_back(8'h4B);
    send_bits(8'h4B, 7);
    beat = 1'b0;
    drain();
    chk("sim_count", countOut, 7);
    // saturation
    gap(21);
    chk("sat_discard", countOut, 7);
    chk("sat_alarm", alarm, ALARM_EXP);
    gap(9);
    chk("sat_after", countOut, 9);
    // health: short period still packed
    reset();
    chk("hl_alarm_clr", alarm, 0);
    gap(4);
    gap(3);
    chk("hl_count", countOut, 3);
    chk("hl_alarm", alarm, ALARM_EXP);
    q.push_back(8'hC3);
    send_bits(8'hC3, 7);
    beat = 1'b0;
    drain();
    // reset mid-word with a pending word
    reset();
    dataReady = 1'b0;
    gap(6);
    send_bits(8'h96, 8);
    send_bits(8'h1F, 5);
    chk("mid_valid", dataValid, 1);
    clr = 1'b1;
    beat = 1'b0;
    tick();
    clr = 1'b0;
    chk("mid_count", countOut, 0);
    chk("mid_data", dataOut, 0);
    chk("mid_valid_clr", dataValid, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_alarm", alarm, 0);
    dataReady = 1'b1;
    q.push_back(8'h5A);
    gap(6);
    send_bits(8'h5A, 8);
    beat = 1'b0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
